// File: rtl/div_seq_rv.sv
// Multicycle radix-2 restoring divider for RV32M/RV64M: DIV, DIVU, REM, REMU.
// One quotient bit per clock; divide-by-zero and signed overflow take an early-out path.
module div_seq_rv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] c_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] nclocks_o
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             init_q;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [CNT_W-1:0] ncl_q, ncl_d;

    logic             is_signed;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic [WIDTH-1:0] min_neg;

    assign is_signed = ~op_q[0];
    assign min_neg   = {1'b1, {(WIDTH-1){1'b0}}};
    assign abs_a     = (is_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    assign abs_b     = (is_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;

    // The shifted partial remainder needs one extra bit before the compare.
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, dsr_q};
    assign rem_sub   = rem_shift[WIDTH-1:0] - dsr_q;

    assign q_fix = (is_signed && sq_q) ? (~dvd_q + 1'b1) : dvd_q;
    assign r_fix = (is_signed && sr_q) ? (~rem_q + 1'b1) : rem_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            init_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            iter_q  <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            ncl_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            iter_q  <= iter_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            ncl_q   <= ncl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        iter_d  = iter_q;
        cnt_d   = (state_q == S_IDLE) ? cnt_q : cnt_q + CNT_W'(1);
        c_d     = c_q;
        ncl_d   = ncl_q;

        unique case (state_q)
            S_IDLE: begin
                if (valid_i && ready_o) begin
                    op_d    = op_i;
                    a_d     = a_i;
                    b_d     = b_i;
                    cnt_d   = '0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                // cnt_q is 0 here, so +2 accounts for this cycle and DONE.
                if (b_q == '0) begin
                    c_d     = op_q[1] ? a_q : '1;
                    ncl_d   = cnt_q + CNT_W'(2);
                    state_d = S_DONE;
                end else if (is_signed && (a_q == min_neg) && (b_q == '1)) begin
                    c_d     = op_q[1] ? '0 : a_q;
                    ncl_d   = cnt_q + CNT_W'(2);
                    state_d = S_DONE;
                end else begin
                    dvd_d   = abs_a;
                    dsr_d   = abs_b;
                    rem_d   = '0;
                    sq_d    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    sr_d    = a_q[WIDTH-1];
                    iter_d  = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Quotient bits shift into the vacated low end of the dividend.
                if (rem_ge) begin
                    rem_d = rem_sub;
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                iter_d = iter_q + 1'b1;
                if (iter_q == IW'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                c_d     = op_q[1] ? r_fix : q_fix;
                ncl_d   = cnt_q + CNT_W'(2);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready_o   = init_q && (state_q == S_IDLE);
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign c_o       = c_q;
    assign nclocks_o = ncl_q;

endmodule

// File: tb/tb_div_seq_rv.sv
// Scoreboard bench for div_seq_rv: a 32-bit and an 8-bit instance fed directed vectors.
// Issue tasks push expected results at accept; per-instance monitors pop on done.
module tb_div_seq_rv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        valid32 = 1'b0, ready32, done32, busy32;
    logic [1:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0, c32;
    logic [31:0] ncl32;

    logic        valid8 = 1'b0, ready8, done8, busy8;
    logic [1:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, c8;
    logic [31:0] ncl8;

    div_seq_rv #(.WIDTH(32), .CNT_W(32)) u_div32 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid32), .ready_o(ready32),
        .op_i(op32), .a_i(a32), .b_i(b32), .c_o(c32), .done_o(done32),
        .busy_o(busy32), .nclocks_o(ncl32)
    );

    div_seq_rv #(.WIDTH(8), .CNT_W(32)) u_div8 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid8), .ready_o(ready8),
        .op_i(op8), .a_i(a8), .b_i(b8), .c_o(c8), .done_o(done8),
        .busy_o(busy8), .nclocks_o(ncl8)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
    vec_t v32 [20] = '{
        '{2'b01, 32'd100,        32'd7,          32'd14,         35},
        '{2'b11, 32'd100,        32'd7,          32'd2,          35},
        '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   35},
        '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   35},
        '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF,   2},
        '{2'b11, 32'd5,          32'd0,          32'd5,          2},
        '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   2},
        '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,          2},
        '{2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   35},
        '{2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          35},
        '{2'b00, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          35},
        '{2'b10, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF,   35},
        '{2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   35},
        '{2'b11, 32'hFFFFFFFF,   32'h10,         32'hF,          35},
        '{2'b00, 32'h80000000,   32'd1,          32'h80000000,   35},
        '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          35},
        '{2'b11, 32'hFFFFFFFE,   32'hFFFFFFFF,   32'hFFFFFFFE,   35},
        '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          35},
        '{2'b10, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   2},
        '{2'b01, 32'd12345,      32'd100,        32'd123,        35}
    };

    vec_t v8 [10] = '{
        '{2'b01, 32'd200,  32'd7,    32'd28,   11},
        '{2'b11, 32'd200,  32'd7,    32'd4,    11},
        '{2'b00, 32'h9C,   32'd7,    32'hF2,   11},
        '{2'b10, 32'h9C,   32'd7,    32'hFE,   11},
        '{2'b00, 32'h80,   32'hFF,   32'h80,   2},
        '{2'b10, 32'h80,   32'hFF,   32'h00,   2},
        '{2'b01, 32'hFF,   32'hFF,   32'd1,    11},
        '{2'b00, 32'd0,    32'd0,    32'hFF,   2},
        '{2'b11, 32'd9,    32'd0,    32'd9,    2},
        '{2'b10, 32'h7F,   32'h80,   32'h7F,   11}
    };

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (done32) begin
            if (q32.size() == 0) begin
                bound_fail("done32_unexpected");
            end else begin
                e = q32.pop_front();
                chk("c32", 64'(c32), 64'(e.c));
                chk("nclocks32", 64'(ncl32), 64'(e.lat));
                chk("latency32", 64'(cyc - e.acc), 64'(e.lat));
                $display("w32 done: c=0x%08h nclocks=%0d", c32, ncl32);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) begin
                bound_fail("done8_unexpected");
            end else begin
                e = q8.pop_front();
                chk("c8", 64'(c8), 64'(e.c[7:0]));
                chk("nclocks8", 64'(ncl8), 64'(e.lat));
                chk("latency8", 64'(cyc - e.acc), 64'(e.lat));
                $display("w8  done: c=0x%02h nclocks=%0d", c8, ncl8);
            end
        end
    end

    // Valid stays high between calls, so the next request's operands sit on
    // the inputs while the previous one is still in flight.
    task automatic issue32(input vec_t v, input bit push);
        int k;
        @(negedge clk);
        valid32 = 1'b1;
        op32 = v.op;
        a32  = v.a;
        b32  = v.b;
        k = 0;
        while (!ready32 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ready32) begin
            bound_fail("ready32_wait");
        end else begin
            if (push) q32.push_back('{v.c, v.lat, cyc});
            @(posedge clk);
        end
    endtask

    task automatic issue8(input vec_t v);
        int k;
        @(negedge clk);
        valid8 = 1'b1;
        op8 = v.op;
        a8  = v.a[7:0];
        b8  = v.b[7:0];
        k = 0;
        while (!ready8 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!ready8) begin
            bound_fail("ready8_wait");
        end else begin
            q8.push_back('{v.c, v.lat, cyc});
            @(posedge clk);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q32.size() != 0 || q8.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q32.size() != 0 || q8.size() != 0) bound_fail("drain");
    endtask

    initial begin
        vec_t rv;

        repeat (2) @(negedge clk);
        chk("rst_ready32", 64'(ready32), 64'd0);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_done32", 64'(done32), 64'd0);
        chk("rst_c32", 64'(c32), 64'd0);
        chk("rst_ncl32", 64'(ncl32), 64'd0);
        chk("rst_ready8", 64'(ready8), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready32", 64'(ready32), 64'd1);
        chk("rel_ready8", 64'(ready8), 64'd1);

        foreach (v32[i]) issue32(v32[i], 1'b1);
        @(negedge clk);
        chk("busy32_inflight", 64'(busy32), 64'd1);
        valid32 = 1'b0;
        drain();

        // Abort a DIVU 1000/3 during its 10th CALC cycle.
        rv = '{2'b01, 32'd1000, 32'd3, 32'd333, 35};
        issue32(rv, 1'b0);
        repeat (11) @(negedge clk);
        chk("pre_abort_busy32", 64'(busy32), 64'd1);
        rst = 1'b1;
        valid32 = 1'b0;
        #1;
        chk("abort_ready32", 64'(ready32), 64'd0);
        chk("abort_busy32", 64'(busy32), 64'd0);
        chk("abort_c32", 64'(c32), 64'd0);
        chk("abort_ncl32", 64'(ncl32), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_done32", 64'(done32), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rel_ready32", 64'(ready32), 64'd1);
        chk("abort_rel_c32", 64'(c32), 64'd0);
        issue32(rv, 1'b1);
        @(negedge clk);
        valid32 = 1'b0;
        drain();

        foreach (v8[i]) issue8(v8[i]);
        @(negedge clk);
        valid8 = 1'b0;
        drain();

        repeat (5) @(negedge clk);
        chk("q32_empty", 64'(q32.size()), 64'd0);
        chk("q8_empty", 64'(q8.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish by t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
